ysyx_22050133_divider: RTL and testbench

//  Iterative radix-2 restoring integer divider for the NPC execute stage.

---
 rtl/ysyx_22050133_div_pkg.sv | 23 ++
 rtl/ysyx_22050133_div_if.sv | 26 ++
 rtl/ysyx_22050133_div_step.sv | 22 ++
 rtl/ysyx_22050133_divider.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_22050133_divider.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050133_div_pkg.sv
// Shared types and constants for the NPC radix-2 restoring divider.
package ysyx_22050133_div_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    // Last iteration index for 64-bit and 32-bit ops (N-1)
    localparam logic [CNT_W-1:0] LAST_CNT_64 = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT_32 = CNT_W'(31);

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050133_div_if.sv
// Request/response bundle between the EXU (master) and the divider (slave).
interface ysyx_22050133_div_if;
    import ysyx_22050133_div_pkg::*;

    logic            flush;
    logic            div_valid;
    logic            divw;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_ready;
    logic            out_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output flush, div_valid, divw, div_signed, dividend, divisor,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  flush, div_valid, divw, div_signed, dividend, divisor,
        output div_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/ysyx_22050133_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift in the quotient bit.
module ysyx_22050133_div_step
    import ysyx_22050133_div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] rem_sh;
    logic          ge;

    assign rem_sh = {rem_i, quo_i[XLEN-1]};
    assign ge     = rem_sh >= {1'b0, dvs_i};
    // When ge holds the true difference is below the divisor, so XLEN bits suffice
    assign rem_o  = ge ? (rem_sh[XLEN-1:0] - dvs_i) : rem_sh[XLEN-1:0];
    assign quo_o  = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/ysyx_22050133_divider.sv
// Iterative RV64M divider (div/divu/rem/remu and w variants), IDLE->DIV->FIX.
// Define YSYX_22050133_DIV_EARLY_OUT_EN to finish |dividend|<|divisor| ops in FIX directly.
module ysyx_22050133_divider
    import ysyx_22050133_div_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ysyx_22050133_div_if.slave bus
);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] wrem_q, wrem_d;
    logic [XLEN-1:0] wquo_q, wquo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            w_q, w_d;
    logic            bypass_q, bypass_d;
    logic            div_ready_q, div_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_ext, rem_spec;
    logic            div_zero, sgn_ovf, early, special, accept;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] q_sgn, r_sgn, fix_quo, fix_rem;

    // Operand preparation: width-extend, take magnitudes, classify special cases
    always_comb begin
        a_ext = bus.divw ? (bus.div_signed ? sext32(bus.dividend[31:0])
                                           : {{(XLEN-32){1'b0}}, bus.dividend[31:0]})
                         : bus.dividend;
        b_ext = bus.divw ? (bus.div_signed ? sext32(bus.divisor[31:0])
                                           : {{(XLEN-32){1'b0}}, bus.divisor[31:0]})
                         : bus.divisor;
        a_neg    = bus.div_signed & a_ext[XLEN-1];
        b_neg    = bus.div_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_ext  = bus.divw ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        sgn_ovf  = bus.div_signed & (b_ext == '1) & (a_ext == min_ext);
        rem_spec = bus.divw ? sext32(bus.dividend[31:0]) : bus.dividend;
    end

`ifdef YSYX_22050133_DIV_EARLY_OUT_EN
    assign early = ~div_zero & (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign special = div_zero | sgn_ovf | early;
    assign accept  = bus.div_valid & div_ready_q & (state_q == ST_IDLE);

    ysyx_22050133_div_step u_step (
        .rem_i (wrem_q),
        .quo_i (wquo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Sign correction and width extension of the iterated result
    always_comb begin
        q_sgn   = q_neg_q ? -wquo_q : wquo_q;
        r_sgn   = r_neg_q ? -wrem_q : wrem_q;
        fix_quo = w_q ? sext32(q_sgn[31:0]) : q_sgn;
        fix_rem = w_q ? sext32(r_sgn[31:0]) : r_sgn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wrem_q      <= '0;
            wquo_q      <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            w_q         <= 1'b0;
            bypass_q    <= 1'b0;
            div_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wrem_q      <= wrem_d;
            wquo_q      <= wquo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            w_q         <= w_d;
            bypass_q    <= bypass_d;
            div_ready_q <= div_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = special ? ST_FIX : ST_DIV;
                ST_DIV:  if (cnt_q == '0) state_d = ST_FIX;
                ST_FIX:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        wrem_d      = wrem_q;
        wquo_d      = wquo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        w_d         = w_q;
        bypass_d    = bypass_q;
        div_ready_d = div_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (bus.flush) begin
            div_ready_d = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    div_ready_d = ~accept;
                    if (accept) begin
                        out_valid_d = 1'b0;
                        cnt_d       = bus.divw ? LAST_CNT_32 : LAST_CNT_64;
                        w_d         = bus.divw;
                        q_neg_d     = a_neg ^ b_neg;
                        r_neg_d     = a_neg;
                        dvs_d       = b_mag;
                        bypass_d    = special;
                        if (special) begin
                            // Special results are final already; FIX just publishes them
                            wquo_d = div_zero ? DIV_BY_ZERO_Q : (sgn_ovf ? min_ext : '0);
                            wrem_d = sgn_ovf ? '0 : rem_spec;
                        end else begin
                            // 32-bit ops start with the magnitude in the top half so N=32 steps suffice
                            wquo_d = bus.divw ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                            wrem_d = '0;
                        end
                    end
                end
                ST_DIV: begin
                    wrem_d = step_rem;
                    wquo_d = step_quo;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                end
                ST_FIX: begin
                    quotient_d  = bypass_q ? wquo_q : fix_quo;
                    remainder_d = bypass_q ? wrem_q : fix_rem;
                    out_valid_d = 1'b1;
                    div_ready_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.div_ready = div_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22050133_divider.sv
// Self-checking bench: directed vector table, randomized ops against an
// arithmetic reference, and flush / async-reset sequences.
module tb_ysyx_22050133_divider;

`ifdef YSYX_22050133_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22050133_div_if bus();

    ysyx_22050133_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          w;
        bit          s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] eq;
        logic [63:0] er;
        int          elat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with native integer division
    function automatic void model(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output int lat);
        bit spec;
        if (w) begin
            logic [31:0] a32, b32, q32, r32;
            int ai, bi;
            int unsigned au, bu;
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; spec = 1'b1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; spec = 1'b1;
            end else begin
                if (s) begin
                    ai = a32; bi = b32; q32 = ai / bi; r32 = ai % bi;
                end else begin
                    au = a32; bu = b32; q32 = au / bu; r32 = au % bu;
                end
                spec = EARLY && (q32 == 32'd0);
            end
            q   = {{32{q32[31]}}, q32};
            r   = {{32{r32[31]}}, r32};
            lat = spec ? 1 : 33;
        end else begin
            longint ai, bi;
            longint unsigned au, bu;
            if (b == 64'd0) begin
                q = '1; r = a; spec = 1'b1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'd0; spec = 1'b1;
            end else begin
                if (s) begin
                    ai = a; bi = b; q = ai / bi; r = ai % bi;
                end else begin
                    au = a; bu = b; q = au / bu; r = au % bu;
                end
                spec = EARLY && (q == 64'd0);
            end
            lat = spec ? 1 : 65;
        end
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = {$urandom, $urandom};
            1:       v = 64'($urandom_range(0, 1000));
            2:       v = -64'($urandom_range(1, 1000));
            3:       v = 64'd0;
            4:       v = '1;
            default: v = {32'($urandom), 1'b1, 31'd0};
        endcase
        return v;
    endfunction

    // Present one request and hold it across a single accept edge
    task automatic start_op(input string tag, input bit w, input bit s,
                            input logic [63:0] a, input logic [63:0] b, output bit ok);
        int guard = 0;
        @(negedge clk);
        while (bus.div_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = (bus.div_ready === 1'b1);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s ready_wait: got div_ready=%b want 1", tag, bus.div_ready);
            return;
        end
        bus.divw       = w;
        bus.div_signed = s;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.div_valid  = 1'b0;
    endtask

    task automatic do_op(input string tag, input bit w, input bit s,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
        bit ok;
        q   = 'x;
        r   = 'x;
        lat = -1;
        start_op(tag, w, s, a, b, ok);
        if (!ok) return;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s done_wait: got out_valid=%b want 1 within 100 edges", tag, bus.out_valid);
            return;
        end
        q = bus.quotient;
        r = bus.remainder;
        chk({tag, " ready_at_done"}, 64'(bus.div_ready), 64'd1);
        $display("op %s w=%0d s=%0d a=%h b=%h -> q=%h r=%h lat=%0d", tag, w, s, a, b, q, r, lat);
    endtask

    initial begin
        logic [63:0] q, r, eq, er;
        int          lat, elat;
        bit          ok, w, s;
        logic [63:0] a, b;

        vecs[0]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[1]  = '{1'b0, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 1};
        vecs[2]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'd0, 1};
        vecs[3]  = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3,
                     64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[4]  = '{1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 64'd0, 33};
        vecs[5]  = '{1'b1, 1'b0, 64'h0000_0000_FFFF_FFF0, 64'd0,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 1};
        vecs[6]  = '{1'b1, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_EF01_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 64'd0, 1};
        vecs[7]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 64'd0, 65};
        vecs[8]  = '{1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
        vecs[9]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 64'd1, 33};
        vecs[10] = '{1'b0, 1'b1, 64'd3, 64'd10, 64'd0, 64'd3, EARLY ? 1 : 65};
        vecs[11] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 64'd0, 65};
        vecs[12] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'd0, 64'h8000_0000_0000_0000, EARLY ? 1 : 65};
        vecs[13] = '{1'b1, 1'b1, 64'hDEAD_0000_0000_0005, 64'h0000_0000_FFFF_FFFE,
                     64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 33};

        bus.flush      = 1'b0;
        bus.div_valid  = 1'b0;
        bus.divw       = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset div_ready", 64'(bus.div_ready), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset quotient", bus.quotient, 64'd0);
        chk("reset remainder", bus.remainder, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after reset", 64'(bus.div_ready), 64'd1);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_op(tag, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b, q, r, lat);
            chk({tag, " quotient"}, q, vecs[i].eq);
            chk({tag, " remainder"}, r, vecs[i].er);
            chk({tag, " latency"}, 64'(lat), 64'(vecs[i].elat));
        end

        for (int i = 0; i < 40; i++) begin
            string tag;
            tag = $sformatf("rnd%0d", i);
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = rand_operand();
            b = rand_operand();
            model(w, s, a, b, eq, er, elat);
            do_op(tag, w, s, a, b, q, r, lat);
            chk({tag, " quotient"}, q, eq);
            chk({tag, " remainder"}, r, er);
            chk({tag, " latency"}, 64'(lat), 64'(elat));
        end

        // Flush ten edges into a 64-bit division
        eq = bus.quotient;
        start_op("flush_mid", 1'b0, 1'b0, 64'd1000, 64'd3, ok);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        $display("op flush_mid div_ready=%b out_valid=%b", bus.div_ready, bus.out_valid);
        chk("flush_mid out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_mid div_ready", 64'(bus.div_ready), 64'd1);
        repeat (70) @(posedge clk);
        #1;
        chk("flush_mid no late result", 64'(bus.out_valid), 64'd0);
        chk("flush_mid quotient kept", bus.quotient, eq);

        do_op("after_flush", 1'b0, 1'b1, 64'd50, 64'd7, q, r, lat);
        chk("after_flush quotient", q, 64'd7);
        chk("after_flush remainder", r, 64'd1);
        chk("after_flush latency", 64'(lat), 64'd65);
        repeat (3) @(posedge clk);
        #1;
        chk("hold out_valid", 64'(bus.out_valid), 64'd1);
        chk("hold quotient", bus.quotient, 64'd7);

        // Flush in the same cycle as an accept cancels the op
        @(negedge clk);
        bus.divw       = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = 64'd100;
        bus.divisor    = 64'd7;
        bus.div_valid  = 1'b1;
        bus.flush      = 1'b1;
        @(posedge clk);
        #1;
        bus.div_valid  = 1'b0;
        bus.flush      = 1'b0;
        $display("op flush_accept div_ready=%b out_valid=%b", bus.div_ready, bus.out_valid);
        chk("flush_accept out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_accept div_ready", 64'(bus.div_ready), 64'd1);
        repeat (70) @(posedge clk);
        #1;
        chk("flush_accept no result", 64'(bus.out_valid), 64'd0);
        chk("flush_accept quotient kept", bus.quotient, 64'd7);

        // Asynchronous reset in the middle of DIV
        start_op("reset_mid", 1'b0, 1'b0, 64'd123456, 64'd11, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("op reset_mid q=%h r=%h out_valid=%b div_ready=%b",
                 bus.quotient, bus.remainder, bus.out_valid, bus.div_ready);
        chk("reset_mid quotient", bus.quotient, 64'd0);
        chk("reset_mid remainder", bus.remainder, 64'd0);
        chk("reset_mid out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_mid div_ready", 64'(bus.div_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release ready before edge", 64'(bus.div_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("release ready after edge", 64'(bus.div_ready), 64'd1);
        do_op("after_reset", 1'b0, 1'b1, 64'd9, 64'd3, q, r, lat);
        chk("after_reset quotient", q, 64'd3);
        chk("after_reset remainder", r, 64'd0);
        chk("after_reset latency", 64'(lat), 64'd65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before 2000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
